// File: rtl/array_frame_rx.sv
// Frame receiver: buffers AXI-side beats in a small FIFO and replays each frame
// as an activate / column-access / precharge sequence on a row-based array.
module array_frame_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TRCD       = 2,
  parameter int TRP        = 2,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi2array_frame_valid,
  output logic        axi2array_frame_ready,
  input  logic [88:0] axi2array_frame_data,
  output logic        array_act,
  output logic        array_pre,
  output logic        array_cs,
  output logic        array_we,
  output logic [15:0] array_row,
  output logic [5:0]  array_col,
  output logic [63:0] array_wdata,
  input  logic [63:0] array_dout,
  output logic        array_rdata_valid,
  output logic [63:0] array_rdata,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  RCD_LAST   = 8'(TRCD > 1 ? TRCD - 2 : 0);
  localparam logic [7:0]  RP_LAST    = 8'(TRP > 1 ? TRP - 2 : 0);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    WAIT_RCD,
    ACCESS,
    PRE,
    WAIT_RP
  } state_t;

  state_t state, state_next;

  logic [88:0] buffer [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, count_next;
  logic        push, pop, empty;
  logic [88:0] head;

  logic [7:0]  wait_cnt, wait_cnt_next;
  logic [15:0] open_row;
  logic        first_beat, first_beat_next;
  logic        row_load, err_set;
  logic        act_next, pre_next, cs_next, we_next;
  logic [5:0]  col_next;
  logic [63:0] wdata_next;
  logic [RD_LAT:0] rd_pipe;

  assign push       = axi2array_frame_valid & axi2array_frame_ready;
  assign count      = wr_ptr - rd_ptr;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  assign empty      = (count == '0);
  assign head       = buffer[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) buffer[wr_ptr[AW-1:0]] <= axi2array_frame_data;
  end

  // Decisions are made here and registered below, so every strobe appears
  // one cycle after the state that decided it; relative spacing is unchanged.
  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    first_beat_next = first_beat;
    pop             = 1'b0;
    row_load        = 1'b0;
    err_set         = 1'b0;
    act_next        = 1'b0;
    pre_next        = 1'b0;
    cs_next         = 1'b0;
    we_next         = 1'b0;
    col_next        = '0;
    wdata_next      = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next      = ACT;
          row_load        = 1'b1;
          first_beat_next = 1'b1;
          if (!head[87]) err_set = 1'b1;
        end
      end
      ACT: begin
        act_next      = 1'b1;
        wait_cnt_next = '0;
        state_next    = (TRCD > 1) ? WAIT_RCD : ACCESS;
      end
      WAIT_RCD: begin
        if (wait_cnt == RCD_LAST) state_next = ACCESS;
        else wait_cnt_next = wait_cnt + 8'd1;
      end
      ACCESS: begin
        if (!empty) begin
          // A fresh sof mid-frame means the previous eof went missing:
          // leave it queued so it opens the next row after precharge.
          if (head[87] && !first_beat) begin
            err_set    = 1'b1;
            state_next = PRE;
          end else begin
            pop             = 1'b1;
            first_beat_next = 1'b0;
            cs_next         = 1'b1;
            we_next         = head[88];
            col_next        = head[85:80];
            wdata_next      = head[63:0];
            if (head[86]) state_next = PRE;
          end
        end
      end
      PRE: begin
        pre_next      = 1'b1;
        wait_cnt_next = '0;
        state_next    = (TRP > 1) ? WAIT_RP : IDLE;
      end
      WAIT_RP: begin
        if (wait_cnt == RP_LAST) state_next = IDLE;
        else wait_cnt_next = wait_cnt + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      axi2array_frame_ready <= 1'b0;
      wait_cnt              <= '0;
      first_beat            <= 1'b0;
      open_row              <= '0;
      frame_err             <= 1'b0;
      array_act             <= 1'b0;
      array_pre             <= 1'b0;
      array_cs              <= 1'b0;
      array_we              <= 1'b0;
      array_row             <= '0;
      array_col             <= '0;
      array_wdata           <= '0;
      rd_pipe               <= '0;
      array_rdata_valid     <= 1'b0;
      array_rdata           <= '0;
    end else begin
      state                 <= state_next;
      wr_ptr                <= wr_ptr + (AW+1)'(push);
      rd_ptr                <= rd_ptr + (AW+1)'(pop);
      axi2array_frame_ready <= (count_next != FULL_COUNT);
      wait_cnt              <= wait_cnt_next;
      first_beat            <= first_beat_next;
      if (row_load) open_row <= head[79:64];
      if (err_set) frame_err <= 1'b1;
      array_act             <= act_next;
      array_pre             <= pre_next;
      array_cs              <= cs_next;
      array_we              <= we_next;
      array_row             <= act_next ? open_row : '0;
      array_col             <= col_next;
      array_wdata           <= wdata_next;
      // Bit k set means a read access happened k cycles ago.
      rd_pipe               <= (rd_pipe << 1) | (RD_LAT+1)'(cs_next & ~we_next);
      array_rdata_valid     <= rd_pipe[RD_LAT];
      array_rdata           <= rd_pipe[RD_LAT] ? array_dout : '0;
    end
  end

endmodule

// File: tb/tb_array_frame_rx.sv
// Scoreboard bench for array_frame_rx: a frame-level reference model queues expected
// array commands and read data; a negedge monitor pops and compares them.
module tb_array_frame_rx;

  localparam int FIFO_DEPTH = 4;
  localparam int TRCD       = 2;
  localparam int TRP        = 2;
  localparam int RD_LAT     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid;
  logic        frame_ready;
  logic [88:0] frame_data;
  logic        array_act, array_pre, array_cs, array_we;
  logic [15:0] array_row;
  logic [5:0]  array_col;
  logic [63:0] array_wdata;
  logic [63:0] array_dout;
  logic        array_rdata_valid;
  logic [63:0] array_rdata;
  logic        frame_err;

  always #5 clk = ~clk;

  array_frame_rx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TRCD(TRCD),
    .TRP(TRP),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi2array_frame_valid(frame_valid),
    .axi2array_frame_ready(frame_ready),
    .axi2array_frame_data(frame_data),
    .array_act(array_act),
    .array_pre(array_pre),
    .array_cs(array_cs),
    .array_we(array_we),
    .array_row(array_row),
    .array_col(array_col),
    .array_wdata(array_wdata),
    .array_dout(array_dout),
    .array_rdata_valid(array_rdata_valid),
    .array_rdata(array_rdata),
    .frame_err(frame_err)
  );

  typedef struct {
    int          kind;   // 0 act, 1 pre, 2 access
    logic [15:0] row;
    logic        we;
    logic [5:0]  col;
    logic [63:0] wdata;
  } ev_t;

  typedef struct {
    int          due;
    logic [63:0] d;
  } rd_t;

  ev_t         exp_ev[$];
  logic [63:0] exp_rd[$];
  int          act_log[$], cs_log[$], pre_log[$], rv_log[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          low_seen = -1;

  logic        m_in_frame = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_row = '0;
  logic [63:0] m_mem [logic [21:0]];

  logic [15:0] em_row = '0;
  logic [21:0] em_k;
  logic [63:0] em_mem [logic [21:0]];
  rd_t         em_q[$];

  int  mk;
  ev_t me;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [63:0] dflt(input logic [21:0] k);
    return {k, ~k, 20'hC0FFE};
  endfunction

  function automatic logic [88:0] beat(input logic rw, input logic sof, input logic eof,
                                       input logic [5:0] col, input logic [15:0] row,
                                       input logic [63:0] wd);
    return {rw, sof, eof, col, row, wd};
  endfunction

  function automatic void push_ev(input int kind, input logic [15:0] row, input logic we,
                                  input logic [5:0] col, input logic [63:0] wd);
    ev_t e;
    e.kind = kind; e.row = row; e.we = we; e.col = col; e.wdata = wd;
    exp_ev.push_back(e);
  endfunction

  // Frame-level reference: each accepted beat is turned into the array commands it implies.
  function automatic void model_accept(input logic [88:0] b);
    logic rw, sof, eof;
    logic [5:0]  col;
    logic [21:0] key;
    rw = b[88]; sof = b[87]; eof = b[86]; col = b[85:80];
    if (m_in_frame && sof) begin
      m_err = 1'b1;
      push_ev(1, '0, 1'b0, '0, '0);
      m_in_frame = 1'b0;
    end
    if (!m_in_frame) begin
      if (!sof) m_err = 1'b1;
      m_row = b[79:64];
      push_ev(0, m_row, 1'b0, '0, '0);
      m_in_frame = 1'b1;
    end
    push_ev(2, m_row, rw, col, b[63:0]);
    key = {m_row, col};
    if (rw) m_mem[key] = b[63:0];
    else exp_rd.push_back(m_mem.exists(key) ? m_mem[key] : dflt(key));
    if (eof) begin
      push_ev(1, '0, 1'b0, '0, '0);
      m_in_frame = 1'b0;
    end
  endfunction

  // Array emulator plus monitor/scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (array_act === 1'b1) em_row = array_row;
    em_k = {em_row, array_col};
    if (array_cs === 1'b1 && array_we === 1'b1) em_mem[em_k] = array_wdata;
    if (array_cs === 1'b1 && array_we === 1'b0) begin
      rd_t r;
      r.due = cyc + RD_LAT;
      r.d   = em_mem.exists(em_k) ? em_mem[em_k] : dflt(em_k);
      em_q.push_back(r);
    end
    if (em_q.size() > 0 && em_q[0].due == cyc) begin
      array_dout = em_q[0].d;
      void'(em_q.pop_front());
    end

    if (!rst) begin
      if (array_act || array_pre || array_cs || array_we)
        chk("strobe_excl", {63'd0, (int'(array_act) + int'(array_pre) + int'(array_cs) <= 1)
                                   && (!array_we || array_cs)}, 64'd1);
      if (array_act || array_pre || array_cs) begin
        mk = array_act ? 0 : (array_pre ? 1 : 2);
        if (mk == 0) act_log.push_back(cyc);
        if (mk == 1) pre_log.push_back(cyc);
        if (mk == 2) cs_log.push_back(cyc);
        if (exp_ev.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_strobe: got kind %0d required none (cycle %0d)", mk, cyc);
        end else begin
          me = exp_ev.pop_front();
          chk("strobe_kind", 64'(mk), 64'(me.kind));
          if (mk == 0 && me.kind == 0) chk("act_row", 64'(array_row), 64'(me.row));
          if (mk == 2 && me.kind == 2) begin
            chk("cs_we", 64'(array_we), 64'(me.we));
            chk("cs_col", 64'(array_col), 64'(me.col));
            if (me.we) chk("cs_wdata", array_wdata, me.wdata);
          end
        end
      end
      if (array_rdata_valid) begin
        rv_log.push_back(cyc);
        if (exp_rd.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rdata: got %0h required no valid (cycle %0d)", array_rdata, cyc);
        end else begin
          chk("rdata", array_rdata, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [88:0] b);
    int   w = 0;
    logic acc = 1'b0;
    frame_valid = 1'b1;
    frame_data  = b;
    while (!acc) begin
      @(negedge clk);
      if (frame_ready) acc = 1'b1;
      else if (low_seen < 0) low_seen = n_acc;
      @(posedge clk); #1;
      w++;
      if (!acc && w > 300) begin
        n_chk++;
        $display("FAIL send_timeout: got ready 0 required 1 (cycle %0d)", cyc);
        break;
      end
    end
    frame_valid = 1'b0;
    if (acc) begin
      n_acc++;
      model_accept(b);
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_ev.size() != 0 || exp_rd.size() != 0) && w < 600) begin
      @(posedge clk);
      w++;
    end
    if (exp_ev.size() != 0 || exp_rd.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_ev.size() + exp_rd.size());
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_log.delete(); cs_log.delete(); pre_log.delete(); rv_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] row;
    int len;
    logic bad_sof, bad_eof;
    frame_valid = 1'b0;
    frame_data  = '0;
    array_dout  = '0;
    rst         = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {57'd0, array_act, array_pre, array_cs, array_we,
                          array_rdata_valid, frame_err, frame_ready}, '0);
    chk("reset_addr", {42'd0, array_row, array_col}, '0);
    chk("reset_data", array_wdata | array_rdata, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_low_at_release", 64'(frame_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_reset", 64'(frame_ready), 64'd1);
    @(posedge clk); #1;

    // Single-beat write frame timing, then a queued second frame
    clear_logs();
    send(beat(1'b1, 1'b1, 1'b1, 6'd5, 16'h1234, 64'hA5));
    send(beat(1'b1, 1'b1, 1'b1, 6'd1, 16'h0042, 64'h77));
    drain();
    chk("t1_act_count", 64'(act_log.size()), 64'd2);
    if (act_log.size() >= 2 && cs_log.size() >= 1 && pre_log.size() >= 1) begin
      chk("t1_act_to_cs", 64'(cs_log[0] - act_log[0]), 64'd2);
      chk("t1_act_to_pre", 64'(pre_log[0] - act_log[0]), 64'd3);
      chk("t1_act_to_next_act", 64'(act_log[1] - act_log[0]), 64'd6);
    end

    // Four-beat read frame: consecutive accesses and read returns
    clear_logs();
    for (int i = 0; i < 4; i++)
      send(beat(1'b0, i == 0, i == 3, 6'(i), 16'h1234, 64'h0));
    send(beat(1'b0, 1'b1, 1'b1, 6'd5, 16'h1234, 64'h0));
    drain();
    chk("t2_cs_count", 64'(cs_log.size()), 64'd5);
    chk("t2_rv_count", 64'(rv_log.size()), 64'd5);
    if (cs_log.size() >= 4 && rv_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) chk("t2_cs_consecutive", 64'(cs_log[i] - cs_log[i-1]), 64'd1);
        chk("t2_rd_latency", 64'(rv_log[i] - cs_log[i]), 64'(RD_LAT + 1));
      end
    end

    // Backpressure: FIFO_DEPTH+2 beats held valid while the row opens
    low_seen = -1;
    n_acc = 0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++)
      send(beat(1'b1, i == 0, i == FIFO_DEPTH + 1, 6'(10 + i), 16'h0200, {32'hBEEF, 32'(i)}));
    chk("t3_accepted_before_full", 64'(low_seen), 64'(FIFO_DEPTH));
    drain();

    // Valid gaps mid-frame
    send(beat(1'b1, 1'b1, 1'b0, 6'd20, 16'h0300, 64'h1111));
    idle(6);
    send(beat(1'b0, 1'b0, 1'b0, 6'd20, 16'hFFFF, 64'h0));
    idle(4);
    send(beat(1'b0, 1'b0, 1'b1, 6'd21, 16'hFFFF, 64'h0));
    drain();
    chk("t4_no_err", 64'(frame_err), 64'(m_err));

    // Protocol errors: missing sof, then missing eof followed by sof
    send(beat(1'b1, 1'b0, 1'b1, 6'd2, 16'h0400, 64'h22));
    drain();
    chk("t5_err_missing_sof", 64'(frame_err), 64'(m_err));
    send(beat(1'b1, 1'b1, 1'b0, 6'd3, 16'h0500, 64'h33));
    send(beat(1'b0, 1'b1, 1'b1, 6'd3, 16'h0500, 64'h0));
    drain();
    chk("t5_err_missing_eof", 64'(frame_err), 64'(m_err));

    // Reset during ACCESS with beats still buffered
    clear_logs();
    for (int i = 0; i < 4; i++)
      send(beat(1'b0, i == 0, 1'b0, 6'(30 + i), 16'h0777, 64'h0));
    for (int w = 0; w < 100 && cs_log.size() == 0; w++) begin @(posedge clk); #1; end
    chk("t6_access_seen", 64'(cs_log.size() > 0), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ev.delete();
    exp_rd.delete();
    m_in_frame = 1'b0;
    m_err      = 1'b0;
    rst        = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("t6_strobes_zero", {57'd0, array_act, array_pre, array_cs, array_we,
                            array_rdata_valid, frame_err, frame_ready}, '0);
    chk("t6_data_zero", array_wdata | array_rdata | {42'd0, array_row, array_col}, '0);
    @(negedge clk);
    chk("t6_ready_back", 64'(frame_ready), 64'd1);
    @(posedge clk); #1;
    idle(8);
    chk("t6_no_late_rdata", 64'(rv_log.size()), 64'd0);
    send(beat(1'b1, 1'b1, 1'b0, 6'd40, 16'h0888, 64'hCAFE));
    send(beat(1'b0, 1'b0, 1'b1, 6'd40, 16'h0888, 64'h0));
    drain();
    chk("t6_err_cleared", 64'(frame_err), 64'(m_err));

    // Randomized frames with occasional protocol errors and valid gaps
    for (int f = 0; f < 40; f++) begin
      len     = $urandom_range(1, 4);
      row     = 16'h0010 + 16'($urandom_range(0, 3));
      bad_sof = ($urandom_range(0, 7) == 0);
      bad_eof = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        send(beat(1'($urandom_range(0, 1)), (i == 0) && !bad_sof, (i == len - 1) && !bad_eof,
                  6'($urandom_range(0, 7)), (i == 0) ? row : 16'($urandom),
                  {$urandom, $urandom}));
      end
    end
    send(beat(1'b0, 1'b1, 1'b1, 6'd0, 16'h0010, 64'h0));
    drain();

    chk("frame_err_final", 64'(frame_err), 64'(m_err));
    chk("queues_empty", 64'(exp_ev.size() + exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/array_frame_rx.md
ARRAY_FRAME_RX -- requirements
Module: array_frame_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, frame buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter TRCD, default 2, cycles from activate to first access.
REQ-003 SHALL have parameter TRP, default 2, cycles from precharge to next activate.
REQ-004 SHALL have parameter RD_LAT, default 2, array_dout latency after read access cycle.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port axi2array_frame_valid  input  1  frame beat valid.
REQ-008 SHALL have port axi2array_frame_ready  output  1  frame beat accepted when valid&ready.
REQ-009 SHALL have port axi2array_frame_data  input  89  [88] rw_flag (1=write), [87] sof, [86] eof, [85:80] col, [79:64] row, [63:0] wdata.
REQ-010 SHALL have ports array_act, array_pre, array_cs, array_we  output  1 each  activate, precharge, column access, write-enable strobes.
REQ-011 SHALL have ports array_row  output  16, array_col  output  6, array_wdata  output  64  array address/data.
REQ-012 SHALL have port array_dout  input  64  raw array read data.
REQ-013 SHALL have ports array_rdata_valid  output  1, array_rdata  output  64  read data returned to the AXI side.
REQ-014 SHALL have port frame_err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL buffer beats in a FIFO_DEPTH FIFO; axi2array_frame_ready = registered "not full"; a pop and push in the same cycle when full SHALL NOT be possible (ready low).
REQ-016 SHALL implement FSM IDLE, ACT, WAIT_RCD, ACCESS, PRE, WAIT_RP.
REQ-017 IDLE: FIFO non-empty -> ACT; head row latched into open-row register.
REQ-018 ACT: array_act=1, array_row=open row for exactly one cycle -> WAIT_RCD.
REQ-019 WAIT_RCD: counter holds TRCD-1 cycles (none if TRCD=1) -> ACCESS.
REQ-020 ACCESS: FIFO non-empty -> pop one beat, array_cs=1, array_we=rw_flag, array_col/array_wdata from beat; FIFO empty -> stall, all strobes 0, stay ACCESS.
REQ-021 ACCESS: popped beat with eof=1 -> PRE next cycle; otherwise stay ACCESS.
REQ-022 PRE: array_pre=1 for one cycle -> WAIT_RP; WAIT_RP holds TRP-1 cycles -> IDLE.
REQ-023 Beat with sof=0 at IDLE head SHALL be processed as sof and set frame_err.
REQ-024 Beat with sof=1 popped in ACCESS (missing eof) SHALL set frame_err, not be popped, and force PRE; it then opens the next row normally.
REQ-025 Row field of non-sof beats SHALL be ignored; open row fixed per frame.
REQ-026 Read access SHALL enter an RD_LAT+1 valid shift register; array_rdata_valid=1 and array_rdata=array_dout registered exactly RD_LAT+1 cycles after the access cycle; back-to-back reads yield back-to-back valids, in order.
REQ-027 Strobes array_act/pre/cs mutually exclusive every cycle; array_we=0 when array_cs=0.
REQ-028 All outputs registered; at most one access per cycle; FIFO pointers wrap modulo FIFO_DEPTH with one extra bit for full/empty.

Reset
REQ-029 rst=1 SHALL return FSM to IDLE, empty FIFO, clear read shift register and frame_err, drive all outputs 0 except axi2array_frame_ready=0 during reset and 1 the cycle after rst falls.
REQ-030 Reset mid-frame SHALL discard buffered beats and in-flight reads without issuing PRE.

Verification
REQ-031 Single write frame sof+eof, row 0x1234, col 5, data 0xA5 -> act (row 0x1234) at cycle T, cs/we at T+2, pre at T+3, IDLE at T+5.
REQ-032 4-beat read frame, cols 0..3 -> four consecutive cs cycles, four consecutive array_rdata_valid pulses starting 3 cycles after first cs, data in order.
REQ-033 Hold frame valid with FIFO_DEPTH+2 beats while FSM in WAIT_RCD -> ready drops after 4 accepted, no beat lost or duplicated.
REQ-034 Gap in valid mid-frame -> ACCESS stalls with cs=0, resumes, no spurious pre.
REQ-035 Frame with sof=0 first, and frame missing eof followed by sof -> frame_err=1, forced pre, second frame completes.
REQ-036 Assert rst during ACCESS with 3 beats buffered -> all outputs 0 next cycle, no rdata_valid afterwards, new frame processes normally.
